// File: rtl/linked_list_fifo_pop_sched_if.sv
// ----------------------------------------------------------------------------
// linked_list_fifo_pop_sched_if
//
// Purpose: groups the scheduler's monitor, pop, return and credit signals
// into one bundle. The scheduler connects through the slave modport. The
// surrounding environment (linked_list_fifo, producers, consumers) connects
// through the master modport.
//
// Handshake semantics: pop is a one-cycle strobe with no back-pressure.
// pop_fifo is meaningful only while pop is high. The linked_list_fifo answers
// with q one cycle later, and at that point out_valid/out_fifo/out_data
// present the word. Consumers never stall the return path. Flow control is
// purely by credits: one credit_return bit pulse per consumed word.
//
// Signals:
//   push_mon       in   copy of the push strobe into linked_list_fifo
//   push_fifo_mon  in   copy of push_fifo
//   enable         in   global pop enable
//   pop            out  pop strobe to linked_list_fifo
//   pop_fifo       out  queue selected for pop (holds when pop is low)
//   q              in   linked_list_fifo read data, valid the cycle after pop
//   out_valid      out  out_data/out_fifo valid
//   out_fifo       out  queue id of out_data
//   out_data       out  popped word (pass-through of q)
//   credit_return  in   per-queue credit return pulses
//   err            out  sticky protocol error
//   dbg_occ        out  per-queue occupancy counters
//   dbg_cred       out  per-queue credit counters
//   dbg_last       out  round-robin pointer
// ----------------------------------------------------------------------------
interface linked_list_fifo_pop_sched_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int FIFOS      = 8,
    parameter int LOG2_FIFO  = (FIFOS > 1) ? $clog2(FIFOS) : 1,
    parameter int LOG2_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
);
    logic                             push_mon;
    logic [LOG2_FIFO-1:0]             push_fifo_mon;
    logic                             enable;
    logic                             pop;
    logic [LOG2_FIFO-1:0]             pop_fifo;
    logic [WIDTH-1:0]                 q;
    logic                             out_valid;
    logic [LOG2_FIFO-1:0]             out_fifo;
    logic [WIDTH-1:0]                 out_data;
    logic [FIFOS-1:0]                 credit_return;
    logic                             err;
    logic [FIFOS-1:0][LOG2_DEPTH:0]   dbg_occ;
    logic [FIFOS-1:0][2:0]            dbg_cred;
    logic [LOG2_FIFO-1:0]             dbg_last;

    modport slave (
        input  push_mon, push_fifo_mon, enable, q, credit_return,
        output pop, pop_fifo, out_valid, out_fifo, out_data, err,
               dbg_occ, dbg_cred, dbg_last
    );

    modport master (
        output push_mon, push_fifo_mon, enable, q, credit_return,
        input  pop, pop_fifo, out_valid, out_fifo, out_data, err,
               dbg_occ, dbg_cred, dbg_last
    );
endinterface

// File: rtl/linked_list_fifo_pop_sched.sv
// ----------------------------------------------------------------------------
// linked_list_fifo_pop_sched
//
// Purpose: round-robin pop scheduler for linked_list_fifo. It learns
// per-queue occupancy by snooping the push side. It holds per-queue
// downstream credits and issues at most one pop per cycle. Each returned
// word is tagged with its queue id.
//
// Ports:
//   clk   in  clock, all state updates on the rising edge
//   rst   in  synchronous active-high reset, priority over all events
//   bus   slave modport of linked_list_fifo_pop_sched_if (see that file)
// ----------------------------------------------------------------------------
module linked_list_fifo_pop_sched #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int FIFOS      = 8,
    parameter int CREDITS    = 2,
    parameter int LOG2_FIFO  = (FIFOS > 1) ? $clog2(FIFOS) : 1,
    parameter int LOG2_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    linked_list_fifo_pop_sched_if.slave   bus
);

    localparam int OCC_W = LOG2_DEPTH + 1;
    // Wide enough to sum FIFOS counters without overflow.
    localparam int TOT_W = OCC_W + LOG2_FIFO;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [FIFOS-1:0][OCC_W-1:0] r_occ;
    logic [FIFOS-1:0][2:0]       r_cred;
    logic [LOG2_FIFO-1:0]        r_last;
    logic [LOG2_FIFO-1:0]        r_pop_fifo_hold;
    logic                        r_out_valid;
    logic [LOG2_FIFO-1:0]        r_out_fifo;
    logic                        r_err;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [FIFOS-1:0]     w_elig;
    logic                 w_grant_any;
    logic [LOG2_FIFO-1:0] w_grant_idx;
    logic [LOG2_FIFO-1:0] w_cand;
    logic [FIFOS-1:0]     w_grant_vec;
    logic [TOT_W-1:0]     w_total;
    logic                 w_push_ovf;
    logic [FIFOS-1:0]     w_push_vec;
    logic [FIFOS-1:0]     w_cred_ovf;

    // Eligibility looks only at registered counters. A push therefore
    // cannot be popped in the cycle it arrives.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < FIFOS; i++) begin
            w_elig[i] = bus.enable && (r_occ[i] != '0) && (r_cred[i] != 3'd0);
        end
    end

    // Round-robin search starting one past the last grant. The modulo keeps
    // non-power-of-two FIFOS counts inside the valid index range.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 1; k <= FIFOS; k++) begin
            w_cand = LOG2_FIFO'((int'(r_last) + k) % FIFOS);
            if (!w_grant_any && w_elig[w_cand]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_grant_vec = '0;
        for (int i = 0; i < FIFOS; i++) begin
            w_grant_vec[i] = w_grant_any && (w_grant_idx == LOG2_FIFO'(i));
        end
    end

    // Total occupancy across all queues. A push is refused once the shared
    // RAM is full. A grant in the same cycle does not rescue it.
    always_comb begin
        w_total = '0;
        for (int i = 0; i < FIFOS; i++) begin
            w_total = w_total + TOT_W'(r_occ[i]);
        end
    end

    assign w_push_ovf = bus.push_mon && (w_total == TOT_W'(DEPTH));

    always_comb begin
        w_push_vec = '0;
        w_cred_ovf = '0;
        for (int i = 0; i < FIFOS; i++) begin
            w_push_vec[i] = bus.push_mon && !w_push_ovf &&
                            (bus.push_fifo_mon == LOG2_FIFO'(i));
            // A return at full credit is harmless only if a grant consumes
            // a credit in the same cycle.
            w_cred_ovf[i] = bus.credit_return[i] &&
                            (r_cred[i] == 3'(CREDITS)) && !w_grant_vec[i];
        end
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFOS; i++) begin
                r_occ[i]  <= '0;
                r_cred[i] <= 3'(CREDITS);
            end
            r_last          <= LOG2_FIFO'(FIFOS - 1);
            r_pop_fifo_hold <= '0;
            r_out_valid     <= 1'b0;
            r_out_fifo      <= '0;
            r_err           <= 1'b0;
        end else begin
            for (int i = 0; i < FIFOS; i++) begin
                if (w_push_vec[i] && !w_grant_vec[i]) begin
                    r_occ[i] <= r_occ[i] + OCC_W'(1);
                end else if (!w_push_vec[i] && w_grant_vec[i]) begin
                    r_occ[i] <= r_occ[i] - OCC_W'(1);
                end

                if (bus.credit_return[i] && !w_grant_vec[i]) begin
                    // Clamp at CREDITS. The overflow is flagged via r_err.
                    if (r_cred[i] != 3'(CREDITS)) begin
                        r_cred[i] <= r_cred[i] + 3'd1;
                    end
                end else if (!bus.credit_return[i] && w_grant_vec[i]) begin
                    r_cred[i] <= r_cred[i] - 3'd1;
                end
            end

            if (w_grant_any) begin
                r_last          <= w_grant_idx;
                r_pop_fifo_hold <= w_grant_idx;
            end

            r_out_valid <= w_grant_any;
            r_out_fifo  <= bus.pop_fifo;

            if (w_push_ovf || (|w_cred_ovf)) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pop       = w_grant_any;
    // Without a grant, pop_fifo keeps its previous value. pop=0 is what
    // tells the RAM that nothing is being popped.
    assign bus.pop_fifo  = w_grant_any ? w_grant_idx : r_pop_fifo_hold;
    assign bus.out_valid = r_out_valid;
    assign bus.out_fifo  = r_out_fifo;
    assign bus.out_data  = bus.q;
    assign bus.err       = r_err;
    assign bus.dbg_occ   = r_occ;
    assign bus.dbg_cred  = r_cred;
    assign bus.dbg_last  = r_last;

endmodule

// File: tb/tb_linked_list_fifo_pop_sched.sv
module tb_linked_list_fifo_pop_sched;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 32;
  localparam int FIFOS   = 8;
  localparam int CREDITS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  linked_list_fifo_pop_sched_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFOS(FIFOS)) bus();

  linked_list_fifo_pop_sched #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .FIFOS(FIFOS), .CREDITS(CREDITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- bench state ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [WIDTH-1:0] exp_q[FIFOS][$];
  logic [WIDTH-1:0] ram[FIFOS][$];
  logic [WIDTH-1:0] push_data;
  logic             auto_cred;
  logic [FIFOS-1:0] man_cred;
  int               pend[FIFOS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int exp_total();
    int s = 0;
    for (int i = 0; i < FIFOS; i++) s += exp_q[i].size();
    return s;
  endfunction

  function automatic int occ_total();
    int s = 0;
    for (int i = 0; i < FIFOS; i++) s += int'(bus.dbg_occ[i]);
    return s;
  endfunction

  // Consumers: either return a credit for every delivered word, or let the
  // stimulus drive returns by hand.
  always_comb begin
    bus.credit_return = '0;
    if (auto_cred) begin
      if (bus.out_valid) bus.credit_return[bus.out_fifo] = 1'b1;
    end else begin
      bus.credit_return = man_cred;
    end
  end

  // Behavioural stand-in for linked_list_fifo: per-queue FIFOs, q registered.
  always @(posedge clk) begin
    int tot;
    if (rst) begin
      for (int i = 0; i < FIFOS; i++) ram[i].delete();
    end else begin
      if (bus.pop) begin
        if (ram[bus.pop_fifo].size() > 0) bus.q <= ram[bus.pop_fifo].pop_front();
        else bus.q <= '0;
      end
      tot = 0;
      for (int i = 0; i < FIFOS; i++) tot += ram[i].size();
      if (bus.push_mon && tot < DEPTH) ram[bus.push_fifo_mon].push_back(push_data);
    end
  end

  // Scoreboard: every delivered word must be the oldest expected word of its queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q[bus.out_fifo].size() == 0) begin
        check("sb_unexpected_word", 32'(exp_q[bus.out_fifo].size()), 32'd1);
      end else begin
        check("sb_data", 32'(bus.out_data), 32'(exp_q[bus.out_fifo].pop_front()));
        pend[bus.out_fifo]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < FIFOS; i++) begin
      exp_q[i].delete();
      pend[i] = 0;
    end
  endtask

  task automatic push_word(input int f, input logic [WIDTH-1:0] d);
    bus.push_mon      = 1'b1;
    bus.push_fifo_mon = 3'(f);
    push_data         = d;
    exp_q[f].push_back(d);
    tick();
    bus.push_mon      = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pop"}, 32'(bus.pop), 32'd0);
    check({tag, "_pop_fifo"}, 32'(bus.pop_fifo), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_fifo"}, 32'(bus.out_fifo), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_last"}, 32'(bus.dbg_last), 32'(FIFOS - 1));
    for (int i = 0; i < FIFOS; i++) begin
      check($sformatf("%s_occ%0d", tag, i), 32'(bus.dbg_occ[i]), 32'd0);
      check($sformatf("%s_cred%0d", tag, i), 32'(bus.dbg_cred[i]), 32'(CREDITS));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt;
    int seq;
    rst               = 1'b1;
    bus.enable        = 1'b0;
    bus.push_mon      = 1'b0;
    bus.push_fifo_mon = '0;
    push_data         = '0;
    auto_cred         = 1'b1;
    man_cred          = '0;
    clear_model();
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Idle with pops enabled but nothing queued.
    bus.enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_pop", 32'(bus.pop), 32'd0);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_err", 32'(bus.err), 32'd0);
    end

    // First push: pop one cycle later, data one cycle after that.
    push_word(3, 8'h05);
    #1;
    check("first_pop", 32'(bus.pop), 32'd1);
    check("first_pop_fifo", 32'(bus.pop_fifo), 32'd3);
    tick();
    check("first_out_valid", 32'(bus.out_valid), 32'd1);
    check("first_out_fifo", 32'(bus.out_fifo), 32'd3);
    check("first_out_data", 32'(bus.out_data), 32'h05);
    repeat (3) tick();

    // Three queues, four words each: strict 0,1,2 rotation with no gaps.
    bus.enable = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int f = 0; f < 3; f++) push_word(f, 8'({3'(f), 5'(r)}));
    bus.enable = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("rr_pop_%0d", k), 32'(bus.pop), 32'd1);
      check($sformatf("rr_fifo_%0d", k), 32'(bus.pop_fifo), 32'(k % 3));
      tick();
    end
    check("rr_done_pop", 32'(bus.pop), 32'd0);
    repeat (3) tick();

    // Credits cap the outstanding words per consumer.
    auto_cred  = 1'b0;
    bus.enable = 1'b0;
    for (int n = 0; n < 5; n++) push_word(1, 8'({3'd1, 5'(n + 8)}));
    bus.enable = 1'b1;
    #1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      cnt += int'(bus.pop);
      tick();
    end
    check("cred_pop_count", 32'(cnt), 32'd2);
    check("cred_occ1", 32'(bus.dbg_occ[1]), 32'd3);
    check("cred_cred1", 32'(bus.dbg_cred[1]), 32'd0);
    man_cred = 8'h02;
    #1;
    check("cred_ret_same_cycle_pop", 32'(bus.pop), 32'd0);
    tick();
    man_cred = '0;
    check("cred_ret_pop", 32'(bus.pop), 32'd1);
    check("cred_ret_pop_fifo", 32'(bus.pop_fifo), 32'd1);
    tick();
    check("cred_ret_single_pop", 32'(bus.pop), 32'd0);
    check("cred_ret_occ1", 32'(bus.dbg_occ[1]), 32'd2);
    repeat (3) tick();

    // Push + grant on one queue, then credit return + grant on one queue.
    auto_cred  = 1'b1;
    bus.enable = 1'b0;
    push_word(4, 8'h90);
    check("pg_occ4_before", 32'(bus.dbg_occ[4]), 32'd1);
    check("pg_cred4_before", 32'(bus.dbg_cred[4]), 32'd2);
    bus.enable        = 1'b1;
    bus.push_mon      = 1'b1;
    bus.push_fifo_mon = 3'd4;
    push_data         = 8'h91;
    exp_q[4].push_back(8'h91);
    #1;
    check("pg_pop", 32'(bus.pop), 32'd1);
    check("pg_pop_fifo", 32'(bus.pop_fifo), 32'd4);
    tick();
    bus.push_mon = 1'b0;
    check("pg_occ4_after", 32'(bus.dbg_occ[4]), 32'd1);
    check("pg_cred4_after", 32'(bus.dbg_cred[4]), 32'd1);
    #1;
    check("pg_next_pop", 32'(bus.pop), 32'd1);
    check("pg_next_pop_fifo", 32'(bus.pop_fifo), 32'd4);
    check("cg_return_same_cycle", 32'(bus.credit_return), 32'h10);
    tick();
    check("cg_occ4", 32'(bus.dbg_occ[4]), 32'd0);
    check("cg_cred4_unchanged", 32'(bus.dbg_cred[4]), 32'd1);
    tick();
    check("cg_cred4_restored", 32'(bus.dbg_cred[4]), 32'd2);
    repeat (3) tick();

    // Fill the shared RAM, then overflow it.
    bus.enable = 1'b0;
    for (int i = 0; i < 30; i++) push_word(i % 8, 8'({3'(i % 8), 5'(i)}));
    check("fill_total", 32'(occ_total()), 32'(DEPTH));
    check("fill_err", 32'(bus.err), 32'd0);
    bus.push_mon      = 1'b1;
    bus.push_fifo_mon = 3'd5;
    push_data         = 8'hEE;
    tick();
    bus.push_mon = 1'b0;
    check("ovf_err", 32'(bus.err), 32'd1);
    check("ovf_occ5_clamped", 32'(bus.dbg_occ[5]), 32'd4);
    check("ovf_total", 32'(occ_total()), 32'(DEPTH));
    repeat (3) tick();
    check("ovf_err_sticky", 32'(bus.err), 32'd1);
    auto_cred = 1'b0;
    man_cred  = 8'h01;
    tick();
    man_cred = '0;
    check("ovf_cred0_clamped", 32'(bus.dbg_cred[0]), 32'(CREDITS));
    check("ovf_err_still", 32'(bus.err), 32'd1);

    // Reset in the middle of a pop stream.
    bus.enable = 1'b1;
    #1;
    check("mid_pop_before_rst", 32'(bus.pop), 32'd1);
    rst = 1'b1;
    clear_model();
    tick();
    check_reset_state("midrst");
    tick();
    rst = 1'b0;
    tick();

    // Credit return at full credit on its own.
    man_cred = 8'h01;
    tick();
    man_cred = '0;
    check("credovf_err", 32'(bus.err), 32'd1);
    check("credovf_cred0", 32'(bus.dbg_cred[0]), 32'(CREDITS));
    rst = 1'b1;
    clear_model();
    tick();
    rst = 1'b0;
    check("credovf_err_cleared", 32'(bus.err), 32'd0);

    // Random pushes, enables and credit returns.
    seq = 0;
    for (int c = 0; c < 4000; c++) begin
      bus.enable = ($urandom_range(0, 7) != 0);
      if (exp_total() < DEPTH && $urandom_range(0, 1) == 1) begin
        int f;
        f = $urandom_range(0, FIFOS - 1);
        bus.push_mon      = 1'b1;
        bus.push_fifo_mon = 3'(f);
        push_data         = 8'({3'(f), 5'(seq)});
        exp_q[f].push_back(push_data);
        seq++;
      end else begin
        bus.push_mon = 1'b0;
      end
      man_cred = '0;
      for (int i = 0; i < FIFOS; i++) begin
        if (pend[i] > 0 && $urandom_range(0, 1) == 1) begin
          man_cred[i] = 1'b1;
          pend[i]--;
        end
      end
      tick();
    end

    // Drain with every credit returned promptly.
    bus.push_mon = 1'b0;
    bus.enable   = 1'b1;
    for (int c = 0; c < 500 && exp_total() > 0; c++) begin
      man_cred = '0;
      for (int i = 0; i < FIFOS; i++) begin
        if (pend[i] > 0) begin
          man_cred[i] = 1'b1;
          pend[i]--;
        end
      end
      tick();
    end
    man_cred = '0;
    repeat (3) tick();
    check("drain_empty", 32'(exp_total()), 32'd0);
    check("drain_occ_total", 32'(occ_total()), 32'd0);
    check("random_err", 32'(bus.err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
